note_tone_gen: RTL

Square-wave tone generator that sits directly downstream of the auto-play note sequencer and the keyboard note mux. It converts the 4-bit note code into an audible square wave on the speaker pin. Pitch and silence changes apply only at half-period boundaries, so the output never produces a runt pulse. It also reports which note is currently sounding, for the LED and 7-segment display logic.

---
 rtl/tone_pkg.sv | 52 +++++
 rtl/note_period_rom.sv | 24 ++
 rtl/note_tone_gen.sv | 99 +++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared note codes, half-period table and code-validity check used by the
// sequencer, keyboard mux and tone generator.
package tone_pkg;

    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C4   = 4'd1;
    localparam logic [3:0] NOTE_D    = 4'd2;
    localparam logic [3:0] NOTE_E    = 4'd3;
    localparam logic [3:0] NOTE_F    = 4'd4;
    localparam logic [3:0] NOTE_G    = 4'd5;
    localparam logic [3:0] NOTE_A    = 4'd6;
    localparam logic [3:0] NOTE_B    = 4'd7;
    localparam logic [3:0] NOTE_C5   = 4'd8;

    // Half-period counts at 100 MHz, before any simulation shift
    localparam int unsigned HALF_W = 18;
    localparam logic [HALF_W-1:0] HALF_C4 = 18'd191110;
    localparam logic [HALF_W-1:0] HALF_D  = 18'd170265;
    localparam logic [HALF_W-1:0] HALF_E  = 18'd151685;
    localparam logic [HALF_W-1:0] HALF_F  = 18'd143172;
    localparam logic [HALF_W-1:0] HALF_G  = 18'd127551;
    localparam logic [HALF_W-1:0] HALF_A  = 18'd113636;
    localparam logic [HALF_W-1:0] HALF_B  = 18'd101239;
    localparam logic [HALF_W-1:0] HALF_C5 = 18'd95557;

    typedef enum logic {
        StSilent,
        StPlaying
    } tone_state_e;

    // Codes 9..15 are treated the same as none
    function automatic logic note_valid(input logic [3:0] code);
        return (code >= NOTE_C4) && (code <= NOTE_C5);
    endfunction

    function automatic logic [HALF_W-1:0] half_period(input logic [3:0] code);
        logic [HALF_W-1:0] half;
        case (code)
            NOTE_C4: half = HALF_C4;
            NOTE_D:  half = HALF_D;
            NOTE_E:  half = HALF_E;
            NOTE_F:  half = HALF_F;
            NOTE_G:  half = HALF_G;
            NOTE_A:  half = HALF_A;
            NOTE_B:  half = HALF_B;
            NOTE_C5: half = HALF_C5;
            default: half = '0;
        endcase
        return half;
    endfunction

endpackage

// File: rtl/note_period_rom.sv
// Combinational note code -> half-period count lookup, scaled by HALF_SHIFT.
// Invalid codes map to zero.
module note_period_rom
    import tone_pkg::*;
#(
    parameter int unsigned HALF_SHIFT = 0,
    parameter int unsigned CNT_W      = 18
) (
    input  logic [3:0]       code,
    output logic [CNT_W-1:0] half
);

    logic [HALF_W-1:0] raw;

    // Table lookup with the simulation speed-up shift applied
    always_comb begin
        raw = '0;
        if (note_valid(code)) begin
            raw = half_period(code) >> HALF_SHIFT;
        end
        half = CNT_W'(raw);
    end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator. Pitch and silence changes are applied only at
// half-period boundaries so the speaker never emits a runt pulse.
module note_tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned HALF_SHIFT = 0,
    parameter int unsigned CNT_W      = 18
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] note_code,
    output logic       speaker,
    output logic [3:0] playing_note,
    output logic       note_strobe
);

    tone_state_e       state_q, state_d;
    logic [3:0]        note_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              speaker_q, speaker_d;
    logic [3:0]        playing_q, playing_d;
    logic              strobe_q, strobe_d;
    logic [CNT_W-1:0]  half;
    logic [CNT_W-1:0]  reload;

    note_period_rom #(
        .HALF_SHIFT (HALF_SHIFT),
        .CNT_W      (CNT_W)
    ) u_rom (
        .code (note_q),
        .half (half)
    );

    assign reload = half - CNT_W'(1);

    // Next state: start, re-pitch or stop only when the counter expires
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        speaker_d = speaker_q;
        playing_d = playing_q;
        strobe_d  = 1'b0;
        unique case (state_q)
            StSilent: begin
                speaker_d = 1'b0;
                playing_d = NOTE_NONE;
                if (note_valid(note_q)) begin
                    cnt_d     = reload;
                    speaker_d = 1'b1;
                    playing_d = note_q;
                    strobe_d  = 1'b1;
                    state_d   = StPlaying;
                end
            end
            StPlaying: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (note_valid(note_q)) begin
                    speaker_d = ~speaker_q;
                    cnt_d     = reload;
                    if (note_q != playing_q) begin
                        playing_d = note_q;
                        strobe_d  = 1'b1;
                    end
                end else begin
                    speaker_d = 1'b0;
                    playing_d = NOTE_NONE;
                    cnt_d     = '0;
                    state_d   = StSilent;
                end
            end
            default: state_d = StSilent;
        endcase
    end

    // State, counter, input sample and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StSilent;
            note_q    <= NOTE_NONE;
            cnt_q     <= '0;
            speaker_q <= 1'b0;
            playing_q <= NOTE_NONE;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_code;
            cnt_q     <= cnt_d;
            speaker_q <= speaker_d;
            playing_q <= playing_d;
            strobe_q  <= strobe_d;
        end
    end

    assign speaker      = speaker_q;
    assign playing_note = playing_q;
    assign note_strobe  = strobe_q;

endmodule
